id_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage pipeline. It drives the ID stage's `ctrl_forw_a`/`ctrl_forw_b` selects, which pick between `drs1`/`drs2`, `fexc`, `fmem` and `fwb`. It also sequences the pipeline through load-use bubbles, branch/jump flushes and data-memory wait states. It keeps a shadow scoreboard of destination registers in EX, MEM and WB, and a saturating stall counter for performance debug.

---
 rtl/id_hazard_ctrl_if.sv | 41 ++++
 rtl/id_hazard_ctrl.sv | 99 +++++++++
 tb/tb_id_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard/forwarding bus: decoded ID fields and memory status in,
// forward selects, stall/bubble/flush controls and the stall counter out.
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_we;
  logic             id_is_load;
  logic             id_is_mem;
  logic             br_taken;
  logic             mem_ready;
  logic [1:0]       ctrl_forw_a;
  logic [1:0]       ctrl_forw_b;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             bubble_ex;
  logic             bubble_wb;
  logic             flush_if;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_we, id_is_load, id_is_mem, br_taken, mem_ready,
    input  ctrl_forw_a, ctrl_forw_b, stall_if, stall_id, stall_ex,
           stall_mem, bubble_ex, bubble_wb, flush_if, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_we, id_is_load, id_is_mem, br_taken, mem_ready,
    output ctrl_forw_a, ctrl_forw_b, stall_if, stall_id, stall_ex,
           stall_mem, bubble_ex, bubble_wb, flush_if, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Hazard and forwarding controller: shadow scoreboard of EX/MEM/WB writers,
// load-use bubbles, memory-wait freeze, branch flush and a stall counter.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  id_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mem;
  } slot_t;

  // Slot index 0 = EX, 1 = MEM, 2 = WB.
  slot_t [2:0]      slot_reg;
  slot_t [2:0]      slot_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  logic [2:0] match_a;
  logic [2:0] match_b;
  logic       lu;
  logic       freeze;

  for (genvar gi = 0; gi < 3; gi++) begin : g_match
    assign match_a[gi] = slot_reg[gi].v & slot_reg[gi].we & bus.id_use_rs1 &
                         (slot_reg[gi].rd == bus.id_rs1) & (bus.id_rs1 != 5'd0);
    assign match_b[gi] = slot_reg[gi].v & slot_reg[gi].we & bus.id_use_rs2 &
                         (slot_reg[gi].rd == bus.id_rs2) & (bus.id_rs2 != 5'd0);
  end

  function automatic logic [1:0] fwd_sel(input logic [2:0] m);
    if (m[0]) return 2'd1;
    if (m[1]) return 2'd2;
    if (m[2]) return 2'd3;
    return 2'd0;
  endfunction

  // A load in MEM is not a hazard: its data already arrives on fmem.
  assign lu     = bus.id_valid & slot_reg[0].v & slot_reg[0].ld & (match_a[0] | match_b[0]);
  assign freeze = slot_reg[1].v & slot_reg[1].mem & ~bus.mem_ready;

  assign bus.ctrl_forw_a = fwd_sel(match_a);
  assign bus.ctrl_forw_b = fwd_sel(match_b);
  assign bus.stall_cnt   = cnt_reg;

  always_comb begin
    bus.stall_if  = 1'b0;
    bus.stall_id  = 1'b0;
    bus.stall_ex  = 1'b0;
    bus.stall_mem = 1'b0;
    bus.bubble_ex = 1'b0;
    bus.bubble_wb = 1'b0;
    bus.flush_if  = 1'b0;
    slot_next     = slot_reg;

    if (freeze) begin
      bus.stall_if  = 1'b1;
      bus.stall_id  = 1'b1;
      bus.stall_ex  = 1'b1;
      bus.stall_mem = 1'b1;
      bus.bubble_wb = 1'b1;
      slot_next[2].v = 1'b0;
    end else begin
      if (lu) begin
        bus.stall_if  = 1'b1;
        bus.stall_id  = 1'b1;
        bus.bubble_ex = 1'b1;
      end else begin
        bus.flush_if = bus.id_valid & bus.br_taken;
      end
      slot_next[2]     = slot_reg[1];
      slot_next[1]     = slot_reg[0];
      slot_next[0].v   = bus.id_valid & ~lu;
      slot_next[0].rd  = bus.id_rd;
      slot_next[0].we  = bus.id_we;
      slot_next[0].ld  = bus.id_is_load;
      slot_next[0].mem = bus.id_is_mem;
    end

    cnt_next = cnt_reg;
    if (bus.stall_id && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      slot_reg <= slot_next;
      cnt_reg  <= cnt_next;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Random plus directed bench for id_hazard_ctrl, checked every cycle against
// a pipeline-level model of the EX/MEM/WB writers.
module tb_id_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   model_ok = 1'b0;
  bit   tb_done = 1'b0;

  id_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model pipeline: index 0 = instruction now in EX, 1 = MEM, 2 = WB.
  int m_v[3];
  int m_rd[3];
  int m_we[3];
  int m_ld[3];
  int m_mem[3];
  int m_cnt;

  function automatic int writer_stage(input int rs, input int use_it);
    for (int k = 0; k < 3; k++)
      if (use_it != 0 && rs != 0 && m_v[k] != 0 && m_we[k] != 0 && m_rd[k] == rs)
        return k + 1;
    return 0;
  endfunction

  function automatic bit m_freeze();
    return m_v[1] != 0 && m_mem[1] != 0 && !bus.mem_ready;
  endfunction

  function automatic bit m_lu();
    return bus.id_valid && m_v[0] != 0 && m_ld[0] != 0 &&
           (writer_stage(int'(bus.id_rs1), int'(bus.id_use_rs1)) == 1 ||
            writer_stage(int'(bus.id_rs2), int'(bus.id_use_rs2)) == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) m_v[k] = 0;
      m_cnt = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit fz, l;
      fz = m_freeze();
      l  = m_lu();
      if (fz || l) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (fz) begin
        m_v[2] = 0;
      end else begin
        for (int k = 2; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1];
          m_ld[k] = m_ld[k-1]; m_mem[k] = m_mem[k-1];
        end
        m_v[0]   = (bus.id_valid && !l) ? 1 : 0;
        m_rd[0]  = int'(bus.id_rd);
        m_we[0]  = int'(bus.id_we);
        m_ld[0]  = int'(bus.id_is_load);
        m_mem[0] = int'(bus.id_is_mem);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !tb_done) begin
      bit fz, l;
      fz = m_freeze();
      l  = m_lu();
      chk("forw_a", int'(bus.ctrl_forw_a), writer_stage(int'(bus.id_rs1), int'(bus.id_use_rs1)));
      chk("forw_b", int'(bus.ctrl_forw_b), writer_stage(int'(bus.id_rs2), int'(bus.id_use_rs2)));
      chk("stall_if", int'(bus.stall_if), int'(fz || l));
      chk("stall_id", int'(bus.stall_id), int'(fz || l));
      chk("stall_ex", int'(bus.stall_ex), int'(fz));
      chk("stall_mem", int'(bus.stall_mem), int'(fz));
      chk("bubble_ex", int'(bus.bubble_ex), int'(l && !fz));
      chk("bubble_wb", int'(bus.bubble_wb), int'(fz));
      chk("flush_if", int'(bus.flush_if), int'(bus.id_valid && bus.br_taken && !l && !fz));
      chk("stall_cnt", int'(bus.stall_cnt), m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit we, input bit ld, input bit mem);
    bus.id_valid   = v;
    bus.id_rs1     = 5'(rs1);
    bus.id_use_rs1 = u1;
    bus.id_rs2     = 5'(rs2);
    bus.id_use_rs2 = u2;
    bus.id_rd      = 5'(rd);
    bus.id_we      = we;
    bus.id_is_load = ld;
    bus.id_is_mem  = mem;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.br_taken  = 1'b0;
    bus.mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Puts a store into the MEM slot, with ID idle afterwards.
  task automatic store_to_mem();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    idle();
    repeat (2) step();

    // Reset state
    do_reset();
    settle();
    chk("rst_stall_id", int'(bus.stall_id), 0);
    chk("rst_flush", int'(bus.flush_if), 0);
    chk("rst_cnt", int'(bus.stall_cnt), 0);

    // Forward priority EX > MEM > WB, then release
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step();
    step();
    set_id(1, 5, 1, 0, 0, 0, 0, 0, 0);
    settle(); chk("fwd_prio_ex", int'(bus.ctrl_forw_a), 1);
    step(); settle(); chk("fwd_prio_mem", int'(bus.ctrl_forw_a), 2);
    step(); settle(); chk("fwd_prio_wb", int'(bus.ctrl_forw_a), 3);
    step(); settle(); chk("fwd_prio_rf", int'(bus.ctrl_forw_a), 0);

    // Load-use: one bubble, then forward from MEM
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 1);
    step();
    set_id(1, 0, 0, 7, 1, 0, 0, 0, 0);
    settle();
    chk("lu_stall_if", int'(bus.stall_if), 1);
    chk("lu_bubble_ex", int'(bus.bubble_ex), 1);
    chk("lu_stall_ex", int'(bus.stall_ex), 0);
    step(); settle();
    chk("lu_fwd_mem", int'(bus.ctrl_forw_b), 2);
    chk("lu_released", int'(bus.stall_id), 0);
    chk("lu_cnt", int'(bus.stall_cnt), 1);

    // x0 writer never forwards or stalls
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("x0_fwd", int'(bus.ctrl_forw_a), 0);
    chk("x0_stall", int'(bus.stall_id), 0);

    // Taken branch (JAL x1): single flush pulse, JAL still enters EX
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0);
    bus.br_taken = 1'b1;
    settle(); chk("br_flush", int'(bus.flush_if), 1);
    step();
    bus.br_taken = 1'b0;
    set_id(0, 1, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("br_flush_end", int'(bus.flush_if), 0);
    chk("br_jal_in_ex", int'(bus.ctrl_forw_a), 1);

    // Memory wait of three cycles, branch ignored during the wait
    do_reset();
    store_to_mem();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.br_taken = 1'b1;
      end else begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.br_taken = 1'b0;
      end
      settle();
      chk("mw_stall_mem", int'(bus.stall_mem), 1);
      chk("mw_bubble_wb", int'(bus.bubble_wb), 1);
      chk("mw_no_flush", int'(bus.flush_if), 0);
      step();
    end
    bus.mem_ready = 1'b1;
    bus.br_taken  = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mw_release", int'(bus.stall_mem), 0);
    chk("mw_cnt", int'(bus.stall_cnt), 3);

    // Reset in the middle of a freeze
    do_reset();
    store_to_mem();
    bus.mem_ready = 1'b0;
    settle(); chk("rf_frozen", int'(bus.stall_ex), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rf_stall_ex", int'(bus.stall_ex), 0);
    chk("rf_bubble_wb", int'(bus.bubble_wb), 0);
    chk("rf_cnt", int'(bus.stall_cnt), 0);

    // Counter saturation
    do_reset();
    store_to_mem();
    bus.mem_ready = 1'b0;
    repeat (20) step();
    settle();
    chk("sat_cnt", int'(bus.stall_cnt), CNT_MAX);
    bus.mem_ready = 1'b1;

    // Randomized traffic, small register range so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      set_id(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0));
      bus.br_taken  = 1'($urandom_range(0, 4) == 0);
      bus.mem_ready = 1'($urandom_range(0, 3) != 0);
    end
    step();
    tb_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
